// File: rtl/bsg_manycore_region_loader.sv
// SPMD region loader: streams a word-addressed image into every tile of a rectangular region,
// fences on store credits, then unfreezes each tile. Optional BSG_MANYCORE_LOADER_SKIP_ZERO_EN skips zero words.
module bsg_manycore_region_loader #(
    parameter int mem_size_p        = 16,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int origin_x_p        = 0,
    parameter int origin_y_p        = 0,
    parameter int load_rows_p       = 1,
    parameter int load_cols_p       = 1,
    parameter int tile_id_ptr_p     = 0,
    parameter int max_out_credits_p = 16,
    localparam int packet_width_lp  = data_width_p + addr_width_p + 2 + 4 + x_cord_width_p + y_cord_width_p
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    output logic [packet_width_lp-1:0] data_o,
    output logic                       v_o,
    input  logic                       ready_i,
    input  logic                       credit_i,
    output logic [addr_width_p-1:0]    addr_o,
    input  logic [data_width_p-1:0]    data_i,
    output logic                       done_o,
    output logic                       busy_o
);

    localparam int stride_lp = data_width_p / 8;
    localparam int col_w_lp  = (load_cols_p > 1) ? $clog2(load_cols_p) : 1;
    localparam int row_w_lp  = (load_rows_p > 1) ? $clog2(load_rows_p) : 1;
    localparam int cred_w_lp = $clog2(max_out_credits_p + 1);

    typedef struct packed {
        logic [data_width_p-1:0]   data;
        logic [addr_width_p-1:0]   addr;
        logic [1:0]                op;
        logic [3:0]                op_ex;
        logic [x_cord_width_p-1:0] x_cord;
        logic [y_cord_width_p-1:0] y_cord;
    } packet_s;

    typedef enum logic [2:0] {
        e_idle,
        e_load,
        e_drain,
        e_unfreeze,
        e_done
    } state_e;

    state_e                  state_r;
    logic [addr_width_p-1:0] load_addr_r;
    logic [col_w_lp-1:0]     col_r;
    logic [row_w_lp-1:0]     row_r;
    logic [cred_w_lp-1:0]    credits_r;

    packet_s                 pkt;
    logic                    is_id_word;
    logic                    skip;
    logic                    has_credit;
    logic                    last_word;
    logic                    last_col;
    logic                    last_row;
    logic                    xfer;
    logic                    store_xfer;
    logic [data_width_p-1:0] tile_id;

    assign is_id_word = (load_addr_r == addr_width_p'(tile_id_ptr_p));
    assign has_credit = (credits_r < cred_w_lp'(max_out_credits_p));
    assign last_word  = (load_addr_r == addr_width_p'(mem_size_p - stride_lp));
    assign last_col   = (col_r == col_w_lp'(load_cols_p - 1));
    assign last_row   = (row_r == row_w_lp'(load_rows_p - 1));
    assign tile_id    = data_width_p'(row_r) * data_width_p'(load_cols_p) + data_width_p'(col_r);

`ifdef BSG_MANYCORE_LOADER_SKIP_ZERO_EN
    // Zero words need no store because targets are pre-zeroed; the tile-id word is always sent.
    assign skip = (state_r == e_load) && (data_i == '0) && !is_id_word;
`else
    assign skip = 1'b0;
`endif

    assign xfer       = v_o & ready_i;
    assign store_xfer = xfer && (state_r == e_load);
    assign addr_o     = load_addr_r / addr_width_p'(stride_lp);
    assign data_o     = pkt;
    assign done_o     = (state_r == e_done);
    assign busy_o     = (state_r != e_idle) && (state_r != e_done);

    // Outgoing packet and valid, built straight from state so contents hold while stalled.
    always_comb begin
        pkt = '0;
        v_o = 1'b0;
        case (state_r)
            e_load: begin
                pkt.data   = is_id_word ? tile_id : data_i;
                pkt.addr   = load_addr_r;
                pkt.op     = 2'b01;
                pkt.op_ex  = 4'b1111;
                pkt.x_cord = x_cord_width_p'(origin_x_p) + x_cord_width_p'(col_r);
                pkt.y_cord = y_cord_width_p'(origin_y_p) + y_cord_width_p'(row_r);
                v_o        = has_credit & ~skip;
            end
            e_unfreeze: begin
                pkt.op     = 2'b10;
                pkt.x_cord = x_cord_width_p'(origin_x_p) + x_cord_width_p'(col_r);
                pkt.y_cord = y_cord_width_p'(origin_y_p) + y_cord_width_p'(row_r);
                v_o        = 1'b1;
            end
            default: begin
                pkt = '0;
                v_o = 1'b0;
            end
        endcase
    end

    // Sequencer: walks words within a tile, tiles row-major, and tracks outstanding stores.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_idle;
            load_addr_r <= '0;
            col_r       <= '0;
            row_r       <= '0;
            credits_r   <= '0;
        end else begin
            // A store and a returning credit in the same cycle cancel out.
            case ({store_xfer, credit_i})
                2'b10:   credits_r <= credits_r + cred_w_lp'(1);
                2'b01:   credits_r <= (credits_r != '0) ? credits_r - cred_w_lp'(1) : credits_r;
                default: credits_r <= credits_r;
            endcase

            case (state_r)
                e_idle, e_done: begin
                    if (start_i) begin
                        state_r     <= e_load;
                        load_addr_r <= '0;
                        col_r       <= '0;
                        row_r       <= '0;
                    end
                end
                e_load: begin
                    if (store_xfer || skip) begin
                        if (last_word) begin
                            load_addr_r <= '0;
                            if (last_col) begin
                                col_r <= '0;
                                if (last_row) begin
                                    row_r   <= '0;
                                    state_r <= e_drain;
                                end else begin
                                    row_r <= row_r + row_w_lp'(1);
                                end
                            end else begin
                                col_r <= col_r + col_w_lp'(1);
                            end
                        end else begin
                            load_addr_r <= load_addr_r + addr_width_p'(stride_lp);
                        end
                    end
                end
                e_drain: begin
                    if (credits_r == '0) begin
                        state_r <= e_unfreeze;
                    end
                end
                e_unfreeze: begin
                    if (xfer) begin
                        if (last_col) begin
                            col_r <= '0;
                            if (last_row) begin
                                row_r   <= '0;
                                state_r <= e_done;
                            end else begin
                                row_r <= row_r + row_w_lp'(1);
                            end
                        end else begin
                            col_r <= col_r + col_w_lp'(1);
                        end
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_manycore_region_loader.sv
// Self-checking bench: 2x2 region at (1,2), 16-byte image, id word at byte 8, two credits,
// scoreboard built from a per-tile image walk.
module tb_bsg_manycore_region_loader;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int XW   = 4;
    localparam int YW   = 4;
    localparam int PW   = DW + AW + 2 + 4 + XW + YW;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int MEMB = 16;
    localparam int PTR  = 8;
    localparam int MAXC = 2;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [PW-1:0] data_o;
    logic          v_o;
    logic          ready_i = 1'b0;
    logic          credit_i = 1'b0;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_i;
    logic          done_o;
    logic          busy_o;

    logic [DW-1:0] mem [0:3];
    logic [PW-1:0] exp_q [$];
    int            total = 0;
    int            bad = 0;
    int            outstanding = 0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_pkt = '0;
    logic          last_store = 1'b0;
    int            ncyc;

    always #5 clk = ~clk;

    assign data_i = mem[addr_o[1:0]];

    bsg_manycore_region_loader #(
        .mem_size_p(MEMB), .data_width_p(DW), .addr_width_p(AW),
        .x_cord_width_p(XW), .y_cord_width_p(YW), .origin_x_p(1), .origin_y_p(2),
        .load_rows_p(ROWS), .load_cols_p(COLS), .tile_id_ptr_p(PTR), .max_out_credits_p(MAXC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .data_o(data_o), .v_o(v_o),
        .ready_i(ready_i), .credit_i(credit_i), .addr_o(addr_o), .data_i(data_i),
        .done_o(done_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                           input logic [1:0] op, input logic [3:0] opex,
                                           input int x, input int y);
        logic [XW-1:0] xc;
        logic [YW-1:0] yc;
        xc = XW'(x);
        yc = YW'(y);
        return {d, a, op, opex, xc, yc};
    endfunction

    // Expected packet stream: every word of every tile row-major, then one unfreeze per tile.
    task automatic build_expected();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int w = 0; w < MEMB / 4; w++) begin
                    logic [DW-1:0] d;
                    d = (w * 4 == PTR) ? DW'(r * COLS + c) : mem[w];
`ifdef BSG_MANYCORE_LOADER_SKIP_ZERO_EN
                    if (d == '0 && w * 4 != PTR) continue;
`endif
                    exp_q.push_back(pack(d, AW'(w * 4), 2'b01, 4'hF, 1 + c, 2 + r));
                end
            end
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back(pack('0, '0, 2'b10, 4'h0, 1 + c, 2 + r));
    endtask

    // One clock cycle, entered and left at the negative edge.
    task automatic cycle(input logic rdy, input logic cred);
        logic [PW-1:0] pkt;
        logic          v;
        logic          st;
        logic [PW-1:0] e;
        pkt = data_o;
        v   = v_o;
        st  = 1'b0;
        if (prev_stall) begin
            check("stall_hold_v", v, 1);
            check("stall_hold_pkt", pkt, prev_pkt);
        end
        if (outstanding >= MAXC) check("credit_gate_v", v, 0);
        ready_i  = rdy;
        credit_i = cred && (outstanding > 0);
        if (v && rdy) begin
            if (exp_q.size() == 0) begin
                check("extra_packet", pkt, 0);
            end else begin
                e = exp_q.pop_front();
                check("packet", pkt, e);
                if (e[12 +: 2] == 2'b10) check("unfreeze_after_fence", outstanding, 0);
                st = (e[12 +: 2] == 2'b01);
            end
        end
        prev_stall = v && !rdy;
        prev_pkt   = pkt;
        @(posedge clk);
        outstanding = outstanding + (st ? 1 : 0) - (credit_i ? 1 : 0);
        last_store  = st;
        @(negedge clk);
        ready_i  = 1'b0;
        credit_i = 1'b0;
    endtask

    task automatic do_start();
        last_store = 1'b0;
        start_i = 1'b1;
        cycle(1'b0, 1'b0);
        start_i = 1'b0;
        check("start_v", v_o, 1);
        check("start_busy", busy_o, 1);
        check("start_done", done_o, 0);
    endtask

    // Run until done_o with random ready (percent) and credits either one cycle late (mode 0) or random.
    task automatic run_to_done(input int pct, input int mode, output int n);
        n = 0;
        while (!done_o && n < 2000) begin
            cycle($urandom_range(99) < pct, (mode == 0) ? last_store : 1'($urandom_range(1)));
            n++;
        end
        check("done_reached", done_o, 1);
        check("done_not_busy", busy_o, 0);
        check("queue_empty", exp_q.size(), 0);
        check("done_data_zero", data_o, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = $urandom | 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_v", v_o, 0);
        check("reset_done", done_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_data", data_o, 0);
        reset_i = 1'b0;
        cycle(1'b1, 1'b0);
        check("idle_v", v_o, 0);

        // Full-rate load, credits one cycle after each store.
        build_expected();
        do_start();
        run_to_done(100, 0, ncyc);
        check("cycles_full_rate", ncyc, 22);

        // Restart from DONE repeats identically.
        build_expected();
        do_start();
        run_to_done(100, 0, ncyc);
        check("cycles_repeat", ncyc, 22);

        // Credit gating with credits withheld.
        build_expected();
        do_start();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("gate_after_two", v_o, 0);
        cycle(1'b1, 1'b0);
        check("gate_holds", v_o, 0);
        cycle(1'b1, 1'b1);
        check("credit_release", v_o, 1);
        cycle(1'b1, 1'b1);
        check("store_and_credit", v_o, 1);
        cycle(1'b1, 1'b0);
        check("gate_again", v_o, 0);
        run_to_done(60, 1, ncyc);

        // Random ready and credits with an image containing zero words.
        for (int i = 0; i < 4; i++) mem[i] = ($urandom_range(2) == 0) ? 32'd0 : $urandom;
        build_expected();
        do_start();
        run_to_done(50, 1, ncyc);

        // Reset during tile 1, then a clean load from tile 0.
        for (int i = 0; i < 4; i++) mem[i] = $urandom | 32'd1;
        build_expected();
        do_start();
        repeat (6) cycle(1'b1, last_store);
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_v", v_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_data", data_o, 0);
        reset_i = 1'b0;
        exp_q.delete();
        outstanding = 0;
        prev_stall  = 1'b0;
        build_expected();
        do_start();
        run_to_done(100, 0, ncyc);
        check("cycles_after_abort", ncyc, 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
